// File: rtl/alu_shift_mem_unit.sv
// ALU, barrel shifter/rotator, async-read data memory and registered C/Z flags.
// Optional rotate support is built only when SHIFTER_ROTATE_EN is defined.
module alu_shift_mem_unit #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic              alu_cin,
  output logic [DATA_W-1:0] alu_out,
  output logic              alu_co,
  output logic              alu_z,
  input  logic [DATA_W-1:0] sh_data,
  input  logic [2:0]        sh_count,
  input  logic              sh_dir,
  input  logic              sh_ro_bar,
  output logic [DATA_W-1:0] sh_out,
  output logic              sh_c,
  output logic              sh_z,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  input  logic              flag_sel,
  input  logic [1:0]        flag_we,
  output logic              C,
  output logic              Z
);

  localparam int unsigned WW    = DATA_W + 1;
  localparam int unsigned SW    = 2 * DATA_W;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // ALU: extra top bit carries the carry (ADD) or borrow (SUB)
  logic [WW-1:0] alu_wide;

  always_comb begin
    alu_wide = '0;
    alu_out  = '0;
    alu_co   = 1'b0;
    case (alu_op)
      3'b000: begin
        alu_wide = {1'b0, alu_a} + {1'b0, alu_b} + WW'(alu_cin);
        alu_out  = alu_wide[DATA_W-1:0];
        alu_co   = alu_wide[DATA_W];
      end
      3'b001: begin
        alu_wide = {1'b0, alu_a} - {1'b0, alu_b} - WW'(alu_cin);
        alu_out  = alu_wide[DATA_W-1:0];
        alu_co   = alu_wide[DATA_W];
      end
      3'b010:  alu_out = alu_a & alu_b;
      3'b011:  alu_out = alu_a | alu_b;
      3'b100:  alu_out = alu_a ^ alu_b;
      3'b101:  alu_out = ~alu_a;
      3'b110:  alu_out = alu_b;
      default: alu_out = alu_a;
    endcase
  end

  assign alu_z = (alu_out == '0);

  // Shifter: double-width shifts keep the bits pushed out for carry and rotate
  logic [SW-1:0] shl_ext;
  logic [SW-1:0] shr_ext;

  assign shl_ext = {{DATA_W{1'b0}}, sh_data} << sh_count;
  assign shr_ext = {sh_data, {DATA_W{1'b0}}} >> sh_count;

`ifdef SHIFTER_ROTATE_EN
  logic [DATA_W-1:0] rot_l;
  logic [DATA_W-1:0] rot_r;

  assign rot_l = shl_ext[DATA_W-1:0] | shl_ext[SW-1:DATA_W];
  assign rot_r = shr_ext[SW-1:DATA_W] | shr_ext[DATA_W-1:0];
`else
  logic unused_ro_bar;

  assign unused_ro_bar = sh_ro_bar;
`endif

  always_comb begin
    sh_out = sh_data;
    sh_c   = 1'b0;
    if (sh_count != '0) begin
`ifdef SHIFTER_ROTATE_EN
      if (!sh_ro_bar) begin
        if (!sh_dir) begin
          sh_out = rot_l;
          sh_c   = rot_l[0];
        end else begin
          sh_out = rot_r;
          sh_c   = rot_r[DATA_W-1];
        end
      end else
`endif
      if (!sh_dir) begin
        sh_out = shl_ext[DATA_W-1:0];
        sh_c   = shl_ext[DATA_W];
      end else begin
        sh_out = shr_ext[SW-1:DATA_W];
        sh_c   = shr_ext[DATA_W-1];
      end
    end
  end

  assign sh_z = (sh_out == '0);

  // Data memory: clears fully on reset, write on edge, asynchronous read
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_addr];

  // Flag register: each flag loads independently from the selected unit
  always_ff @(posedge clk) begin
    if (reset) begin
      C <= 1'b0;
      Z <= 1'b0;
    end else begin
      if (flag_we[1]) C <= flag_sel ? sh_c : alu_co;
      if (flag_we[0]) Z <= flag_sel ? sh_z : alu_z;
    end
  end

endmodule

// File: tb/tb_alu_shift_mem_unit.sv
// Self-checking bench for alu_shift_mem_unit: directed cases then randomized
// traffic against a bit-serial / integer reference model.
module tb_alu_shift_mem_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b;
  logic       alu_cin;
  logic [7:0] alu_out;
  logic       alu_co, alu_z;
  logic [7:0] sh_data;
  logic [2:0] sh_count;
  logic       sh_dir, sh_ro_bar;
  logic [7:0] sh_out;
  logic       sh_c, sh_z;
  logic       mem_write;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       flag_sel;
  logic [1:0] flag_we;
  logic       C, Z;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem_m [256];
  logic       c_m, z_m;

  always #5 clk = ~clk;

  alu_shift_mem_unit #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_co(alu_co), .alu_z(alu_z),
    .sh_data(sh_data), .sh_count(sh_count), .sh_dir(sh_dir), .sh_ro_bar(sh_ro_bar),
    .sh_out(sh_out), .sh_c(sh_c), .sh_z(sh_z),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .flag_sel(flag_sel), .flag_we(flag_we), .C(C), .Z(Z)
  );

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Integer-arithmetic ALU reference
  function automatic void ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input logic cin, output logic [7:0] o, output logic co);
    int s;
    co = 1'b0;
    case (op)
      3'd0: begin s = int'(a) + int'(b) + int'(cin); o = 8'(s); co = (s > 255); end
      3'd1: begin s = int'(a) - int'(b) - int'(cin); o = 8'(s); co = (s < 0); end
      3'd2: o = a & b;
      3'd3: o = a | b;
      3'd4: o = a ^ b;
      3'd5: o = ~a;
      3'd6: o = b;
      default: o = a;
    endcase
  endfunction

  // Shifter reference: moves one bit position per step
  function automatic void ref_sh(input logic [7:0] d, input logic [2:0] n, input logic dir,
                                 input logic ro_bar, output logic [7:0] o, output logic c);
    logic [7:0] v;
    logic       last;
    logic       rot;
    v    = d;
    last = 1'b0;
`ifdef SHIFTER_ROTATE_EN
    rot = ~ro_bar;
`else
    rot = 1'b0 & ro_bar;
`endif
    for (int k = 0; k < int'(n); k++) begin
      if (!dir) begin
        last = v[7];
        v    = {v[6:0], rot ? v[7] : 1'b0};
      end else begin
        last = v[0];
        v    = {rot ? v[0] : 1'b0, v[7:1]};
      end
    end
    o = v;
    if (n == 3'd0)  c = 1'b0;
    else if (rot)   c = dir ? v[7] : v[0];
    else            c = last;
  endfunction

  task automatic check_comb(input string tag);
    logic [7:0] ao, so;
    logic       aco, sc;
    ref_alu(alu_op, alu_a, alu_b, alu_cin, ao, aco);
    ref_sh(sh_data, sh_count, sh_dir, sh_ro_bar, so, sc);
    chk8({tag, "_alu_out"}, alu_out, ao);
    chk1({tag, "_alu_co"}, alu_co, aco);
    chk1({tag, "_alu_z"}, alu_z, ao == 8'h00);
    chk8({tag, "_sh_out"}, sh_out, so);
    chk1({tag, "_sh_c"}, sh_c, sc);
    chk1({tag, "_sh_z"}, sh_z, so == 8'h00);
    chk8({tag, "_rdata"}, mem_rdata, mem_m[mem_addr]);
  endtask

  // Apply one rising edge to the reference state, using inputs as held
  task automatic model_edge();
    logic [7:0] ao, so;
    logic       aco, sc;
    ref_alu(alu_op, alu_a, alu_b, alu_cin, ao, aco);
    ref_sh(sh_data, sh_count, sh_dir, sh_ro_bar, so, sc);
    if (reset) begin
      foreach (mem_m[i]) mem_m[i] = 8'h00;
      c_m = 1'b0;
      z_m = 1'b0;
    end else begin
      if (mem_write)  mem_m[mem_addr] = mem_wdata;
      if (flag_we[1]) c_m = flag_sel ? sc : aco;
      if (flag_we[0]) z_m = flag_sel ? (so == 8'h00) : (ao == 8'h00);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] so;
    logic       sc;
    reset = 1'b1; alu_op = 3'd0; alu_a = 8'h00; alu_b = 8'h00; alu_cin = 1'b0;
    sh_data = 8'h00; sh_count = 3'd0; sh_dir = 1'b0; sh_ro_bar = 1'b1;
    mem_write = 1'b1; mem_addr = 8'h10; mem_wdata = 8'h77; flag_sel = 1'b0; flag_we = 2'b11;
    c_m = 1'b0; z_m = 1'b0;
    foreach (mem_m[i]) mem_m[i] = 8'h00;

    // Reset overrides write and flag enables
    @(negedge clk); tick(); tick();
    chk1("reset_C", C, 1'b0);
    chk1("reset_Z", Z, 1'b0);
    chk8("reset_mem10", mem_rdata, 8'h00);
    @(negedge clk);
    reset = 1'b0; mem_write = 1'b0; flag_we = 2'b00;

    // ADD wrap with flag load from ALU
    alu_op = 3'd0; alu_a = 8'hFF; alu_b = 8'h01; alu_cin = 1'b0; flag_we = 2'b11; flag_sel = 1'b0;
    #1;
    chk8("add_ff_01_out", alu_out, 8'h00);
    chk1("add_ff_01_co", alu_co, 1'b1);
    chk1("add_ff_01_z", alu_z, 1'b1);
    tick();
    chk1("add_flags_C", C, 1'b1);
    chk1("add_flags_Z", Z, 1'b1);

    @(negedge clk);
    flag_we = 2'b00;
    alu_op = 3'd1; alu_a = 8'h05; alu_b = 8'h07; alu_cin = 1'b0;
    #1;
    chk8("sub_05_07_out", alu_out, 8'hFE);
    chk1("sub_05_07_co", alu_co, 1'b1);
    chk1("sub_05_07_z", alu_z, 1'b0);
    alu_op = 3'd2; alu_a = 8'hF0; alu_b = 8'h0F;
    #1;
    chk8("and_f0_0f_out", alu_out, 8'h00);
    chk1("and_f0_0f_z", alu_z, 1'b1);

    sh_ro_bar = 1'b1;
    sh_data = 8'h81; sh_count = 3'd1; sh_dir = 1'b0;
    #1;
    chk8("shl_81_1_out", sh_out, 8'h02);
    chk1("shl_81_1_c", sh_c, 1'b1);
    sh_count = 3'd7; sh_dir = 1'b1;
    #1;
    chk8("shr_81_7_out", sh_out, 8'h01);
    chk1("shr_81_7_c", sh_c, 1'b0);
    sh_count = 3'd0;
    #1;
    chk8("sh_cnt0_out", sh_out, 8'h81);
    chk1("sh_cnt0_c", sh_c, 1'b0);

    sh_ro_bar = 1'b0; sh_data = 8'h01; sh_count = 3'd1; sh_dir = 1'b1;
    #1;
`ifdef SHIFTER_ROTATE_EN
    chk8("ror_01_1_out", sh_out, 8'h80);
`else
    chk8("ror_01_1_out", sh_out, 8'h00);
`endif
    chk1("ror_01_1_c", sh_c, 1'b1);

    // Shifter result zero with carry: only C loads
    sh_ro_bar = 1'b1; sh_data = 8'h80; sh_count = 3'd1; sh_dir = 1'b0;
    flag_sel = 1'b1; flag_we = 2'b10;
    tick();
    chk1("shflag_C", C, 1'b1);
    chk1("shflag_Z_hold", Z, 1'b1);

    // Write then read same address, old data before the edge
    @(negedge clk);
    flag_we = 2'b00; mem_write = 1'b1; mem_addr = 8'h3C; mem_wdata = 8'hA5;
    #1;
    chk8("mem_3c_before", mem_rdata, 8'h00);
    tick();
    chk8("mem_3c_after", mem_rdata, 8'hA5);
    @(negedge clk);
    mem_write = 1'b0; reset = 1'b1;
    #1;
    chk8("mem_3c_in_reset", mem_rdata, 8'hA5);
    tick();
    chk8("mem_3c_post_reset", mem_rdata, 8'h00);
    chk1("post_reset_C", C, 1'b0);
    chk1("post_reset_Z", Z, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic; small address range so reads hit written words
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      reset     = ($urandom_range(0, 39) == 0);
      alu_op    = 3'($urandom);
      alu_a     = 8'($urandom);
      alu_b     = ($urandom_range(0, 7) == 0) ? alu_a : 8'($urandom);
      alu_cin   = 1'($urandom);
      sh_data   = 8'($urandom);
      sh_count  = 3'($urandom);
      sh_dir    = 1'($urandom);
      sh_ro_bar = 1'($urandom);
      mem_write = 1'($urandom);
      mem_addr  = {4'h0, 4'($urandom)};
      mem_wdata = 8'($urandom);
      flag_sel  = 1'($urandom);
      flag_we   = 2'($urandom);
      #1;
      check_comb("rnd");
      tick();
      chk1("rnd_C", C, c_m);
      chk1("rnd_Z", Z, z_m);
      chk8("rnd_rdata_post", mem_rdata, mem_m[mem_addr]);
    end

    // Exhaustive shifter sweep on one pattern
    @(negedge clk);
    reset = 1'b0; mem_write = 1'b0; flag_we = 2'b00; sh_data = 8'hB4;
    for (int k = 0; k < 32; k++) begin
      sh_count  = 3'(k);
      sh_dir    = k[3];
      sh_ro_bar = k[4];
      #1;
      ref_sh(sh_data, sh_count, sh_dir, sh_ro_bar, so, sc);
      chk8("sweep_out", sh_out, so);
      chk1("sweep_c", sh_c, sc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_shift_mem_unit.md
ALU_SHIFT_MEM_UNIT -- requirements
Module: alu_shift_mem_unit

Interface
REQ-001 Parameter DATA_W, default 8, datapath width; only 8 is supported.
REQ-002 Parameter ADDR_W, default 8, data-memory address width (depth 2^ADDR_W).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 alu_op  in  3  ALU operation select.
REQ-006 alu_a  in  8  ALU operand A.
REQ-007 alu_b  in  8  ALU operand B.
REQ-008 alu_cin  in  1  ALU carry/borrow in.
REQ-009 alu_out  out  8  ALU result, combinational.
REQ-010 alu_co  out  1  ALU carry/borrow out, combinational.
REQ-011 alu_z  out  1  1 when alu_out==0.
REQ-012 sh_data  in  8  shifter input.
REQ-013 sh_count  in  3  shift/rotate amount, 0..7.
REQ-014 sh_dir  in  1  0 = left, 1 = right.
REQ-015 sh_ro_bar  in  1  1 = logical shift, 0 = rotate.
REQ-016 sh_out  out  8  shifter result, combinational.
REQ-017 sh_c  out  1  last bit shifted/rotated out.
REQ-018 sh_z  out  1  1 when sh_out==0.
REQ-019 mem_write  in  1  data-memory write enable.
REQ-020 mem_addr  in  ADDR_W  data-memory address.
REQ-021 mem_wdata  in  8  data-memory write data.
REQ-022 mem_rdata  out  8  data-memory read data.
REQ-023 flag_sel  in  1  flag source: 0 = ALU, 1 = shifter.
REQ-024 flag_we  in  2  bit1 loads C, bit0 loads Z.
REQ-025 C, Z  out  1 each  registered carry and zero flags.

Function
REQ-026 alu_op: 000 ADD a+b+cin; 001 SUB a-b-cin; 010 AND; 011 OR; 100 XOR; 101 NOT a; 110 pass b; 111 pass a.
REQ-027 ADD co = bit 8 of the 9-bit sum; SUB co = 1 on borrow (a < b+cin, unsigned); logic/pass ops co = 0; results wrap modulo 256.
REQ-028 Shift left by n: out = data<<n, zero fill, sh_c = data[8-n]; right: out = data>>n, zero fill, sh_c = data[n-1].
REQ-029 Rotate left/right by n: bits wrap around; sh_c = out[0] for left, out[7] for right.
REQ-030 sh_count==0: sh_out = sh_data, sh_c = 0, for shift and rotate alike.
REQ-031 Memory: 2^ADDR_W x 8; write on rising clk when mem_write=1; asynchronous read of mem_addr.
REQ-032 Read of the address being written returns old data until the edge, new data combinationally after it.
REQ-033 On rising clk, if flag_we[1]: C <= (flag_sel ? sh_c : alu_co); if flag_we[0]: Z <= (flag_sel ? sh_z : alu_z); otherwise hold.

Reset
REQ-034 reset=1 at a rising edge: C=0, Z=0, all memory words cleared to 0; reset overrides mem_write and flag_we in that cycle.
REQ-035 Combinational outputs follow their inputs during reset; mem_rdata reads 0 after the reset edge.

Configuration
REQ-036 Macro SHIFTER_ROTATE_EN defined: rotate behaves per REQ-029.
REQ-037 Macro SHIFTER_ROTATE_EN undefined: sh_ro_bar is ignored, all operations are logical shifts per REQ-028, and no rotate logic is built.

Verification
REQ-038 ADD a=0xFF, b=0x01, cin=0 -> alu_out 0x00, alu_co 1, alu_z 1; with flag_we=11, flag_sel=0, the next edge gives C=1, Z=1.
REQ-039 SUB a=0x05, b=0x07, cin=0 -> alu_out 0xFE, alu_co 1, alu_z 0; AND 0xF0,0x0F -> 0x00, z 1.
REQ-040 Shift left 0x81 by 1 -> sh_out 0x02, sh_c 1; shift right 0x81 by 7 -> 0x01, sh_c 0; count 0 -> 0x81, sh_c 0.
REQ-041 Rotate (macro on) right 0x01 by 1 -> 0x80, sh_c 1; macro off, same stimulus -> 0x00, sh_c 1.
REQ-042 Write 0xA5 at 0x3C, read 0x3C -> 0xA5; apply reset for one edge -> read 0x00, C=0, Z=0.
REQ-043 flag_we=10, flag_sel=1, shifter result 0x00 with sh_c=1 -> C=1, Z unchanged.
